// File: rtl/usart_pkg.sv
// Shared encodings and constants for the gen2 USART receive path.
// Oversampling geometry and the UCSZ character-width decode live here.
package usart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } rx_state_e;

  localparam logic [2:0] CS_5 = 3'd0;
  localparam logic [2:0] CS_6 = 3'd1;
  localparam logic [2:0] CS_7 = 3'd2;
  localparam logic [2:0] CS_8 = 3'd3;
  localparam logic [2:0] CS_9 = 3'd7;

  localparam logic [1:0] PM_NONE = 2'b00;
  localparam logic [1:0] PM_RSVD = 2'b01;
  localparam logic [1:0] PM_EVEN = 2'b10;
  localparam logic [1:0] PM_ODD  = 2'b11;

  localparam logic [4:0] NS_16X    = 5'd16;
  localparam logic [4:0] VOTE1_16X = 5'd8;
  localparam logic [4:0] VOTE2_16X = 5'd9;
  localparam logic [4:0] VOTE3_16X = 5'd10;

  localparam logic [4:0] NS_8X    = 5'd8;
  localparam logic [4:0] VOTE1_8X = 5'd4;
  localparam logic [4:0] VOTE2_8X = 5'd5;
  localparam logic [4:0] VOTE3_8X = 5'd6;

  // Reserved UCSZ codes 4..6 fall back to 8-bit characters.
  function automatic logic [3:0] char_width(input logic [2:0] cs);
    case (cs)
      CS_5:    char_width = 4'd5;
      CS_6:    char_width = 4'd6;
      CS_7:    char_width = 4'd7;
      CS_8:    char_width = 4'd8;
      CS_9:    char_width = 4'd9;
      default: char_width = 4'd8;
    endcase
  endfunction

endpackage

// File: rtl/usart_rx_fifo.sv
// Synchronous receive FIFO; pointers carry an extra wrap bit so full and
// empty are distinguishable without a separate counter.
module usart_rx_fifo
  import usart_pkg::*;
#(
  parameter int WIDTH = 11,
  parameter int DEPTH = 4
) (
  input  logic                           clk_i,
  input  logic                           rst_i,
  input  logic                           flush_i,
  input  logic                           push_i,
  input  logic                           pop_i,
  input  logic [WIDTH-1:0]               wdata_i,
  output logic [WIDTH-1:0]               rdata_o,
  output logic                           empty_o,
  output logic                           full_o,
  output logic [$clog2(DEPTH+1)-1:0]     level_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = $clog2(DEPTH+1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wr_q;
  logic [AW:0]      rd_q;
  logic             do_push;
  logic             do_pop;

  assign empty_o = (wr_q == rd_q);
  assign full_o  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);

  // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  assign level_o = LW'(wr_q - rd_q);
  assign rdata_o = mem_q[rd_q[AW-1:0]];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_q <= '0;
      rd_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (flush_i) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_q[AW-1:0]] <= wdata_i;
        wr_q                <= wr_q + {{AW{1'b0}}, 1'b1};
      end
      if (do_pop) begin
        rd_q <= rd_q + {{AW{1'b0}}, 1'b1};
      end
    end
  end

endmodule

// File: rtl/usart_rx_gen2.sv
// USART receive path: rxd synchroniser, baud tick generator, oversampling
// frame FSM with 3-sample majority vote, and per-entry error-flagged FIFO.
module usart_rx_gen2
  import usart_pkg::*;
#(
  parameter int DATA_W_MAX = 9,
  parameter int FIFO_DEPTH = 4,
  parameter int UBRR_W     = 12
) (
  input  logic                               cp2,
  input  logic                               ireset,
  input  logic                               rx_en,
  input  logic                               rxd,
  input  logic [UBRR_W-1:0]                  ubrr,
  input  logic                               u2x,
  input  logic [2:0]                         char_size,
  input  logic [1:0]                         parity_mode,
  input  logic                               rx_pop,
  output logic                               rx_valid,
  output logic [DATA_W_MAX-1:0]              rx_data,
  output logic                               rx_fe,
  output logic                               rx_pe,
  output logic                               rx_dor,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]    fifo_level,
  output logic                               busy
);

  localparam int FW = DATA_W_MAX + 2;

  // Handshake: rx_valid holds the head (rx_data/rx_fe/rx_pe) stable until a
  // one-cycle rx_pop is seen while rx_valid=1; rx_pop while empty is ignored.

  logic [1:0]            sync_q;
  logic                  rxd_s;
  logic [UBRR_W-1:0]     baud_q, baud_d;
  logic                  tick;

  rx_state_e             state_q, state_d;
  logic [4:0]            samp_q, samp_d;
  logic [3:0]            bit_q, bit_d;
  logic [DATA_W_MAX-1:0] shreg_q, shreg_d;
  logic                  par_q, par_d;
  logic [1:0]            v_q, v_d;
  logic [3:0]            cfg_w_q, cfg_w_d;
  logic [1:0]            cfg_par_q, cfg_par_d;
  logic                  cfg_u2x_q, cfg_u2x_d;
  logic                  dor_q, dor_d;

  logic [4:0]            ns, vp1, vp2, vp3, samp_cur;
  logic                  at_v3, at_end, maj, par_x, pe_calc;
  logic [3:0]            w_dec;
  logic                  commit, commit_fe, commit_pe;
  logic [FW-1:0]         fifo_rdata;
  logic                  fifo_empty, fifo_full, overrun;

  assign rxd_s = sync_q[1];
  assign tick  = rx_en && (baud_q == '0);

  always_comb begin
    baud_d = baud_q - UBRR_W'(1);
    if (!rx_en || baud_q == '0) begin
      baud_d = ubrr;
    end
  end

  assign ns  = cfg_u2x_q ? NS_8X    : NS_16X;
  assign vp1 = cfg_u2x_q ? VOTE1_8X : VOTE1_16X;
  assign vp2 = cfg_u2x_q ? VOTE2_8X : VOTE2_16X;
  assign vp3 = cfg_u2x_q ? VOTE3_8X : VOTE3_16X;

  assign samp_cur = samp_q + 5'd1;
  assign at_v3    = (samp_cur == vp3);
  assign at_end   = (samp_cur == ns);
  assign maj      = (v_q[0] & v_q[1]) | (v_q[0] & rxd_s) | (v_q[1] & rxd_s);

  assign w_dec = (int'(char_width(char_size)) > DATA_W_MAX) ? 4'(DATA_W_MAX)
                                                             : char_width(char_size);

  always_comb begin
    par_x = (^shreg_q) ^ par_q;
    case (cfg_par_q)
      PM_EVEN: pe_calc = par_x;
      PM_ODD:  pe_calc = !par_x;
      default: pe_calc = 1'b0;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    samp_d    = samp_q;
    bit_d     = bit_q;
    shreg_d   = shreg_q;
    par_d     = par_q;
    v_d       = v_q;
    cfg_w_d   = cfg_w_q;
    cfg_par_d = cfg_par_q;
    cfg_u2x_d = cfg_u2x_q;
    commit    = 1'b0;
    commit_fe = 1'b0;
    commit_pe = 1'b0;
    if (!rx_en) begin
      state_d = ST_IDLE;
      samp_d  = '0;
      bit_d   = '0;
    end else if (tick) begin
      if (state_q == ST_IDLE) begin
        if (!rxd_s) begin
          cfg_w_d   = w_dec;
          cfg_par_d = parity_mode;
          cfg_u2x_d = u2x;
          samp_d    = 5'd1;
          bit_d     = '0;
          shreg_d   = '0;
          par_d     = 1'b0;
          state_d   = ST_START;
        end
      end else begin
        samp_d = at_end ? 5'd0 : samp_cur;
        if (samp_cur == vp1) v_d[0] = rxd_s;
        if (samp_cur == vp2) v_d[1] = rxd_s;
        case (state_q)
          ST_START: begin
            if (at_v3 && maj) begin
              state_d = ST_IDLE;
              samp_d  = '0;
            end else if (at_end) begin
              state_d = ST_DATA;
            end
          end
          ST_DATA: begin
            if (at_v3) begin
              shreg_d[bit_q] = maj;
              bit_d          = bit_q + 4'd1;
            end
            if (at_end && bit_q == cfg_w_q) begin
              state_d = cfg_par_q[1] ? ST_PARITY : ST_STOP;
            end
          end
          ST_PARITY: begin
            if (at_v3) par_d = maj;
            if (at_end) state_d = ST_STOP;
          end
          ST_STOP: begin
            // Commit at the vote point so an early next start bit is not missed.
            if (at_v3) begin
              commit    = 1'b1;
              commit_fe = !maj;
              commit_pe = pe_calc;
              state_d   = ST_IDLE;
              samp_d    = '0;
            end
          end
          default: begin
            state_d = ST_IDLE;
            samp_d  = '0;
          end
        endcase
      end
    end
  end

  assign overrun = commit && fifo_full && !rx_pop;

  always_comb begin
    dor_d = dor_q;
    if (!rx_en) begin
      dor_d = 1'b0;
    end else begin
      if (rx_pop && rx_valid) dor_d = 1'b0;
      if (overrun) dor_d = 1'b1;
    end
  end

  always_ff @(posedge cp2) begin
    if (ireset) begin
      sync_q    <= 2'b11;
      baud_q    <= ubrr;
      state_q   <= ST_IDLE;
      samp_q    <= '0;
      bit_q     <= '0;
      shreg_q   <= '0;
      par_q     <= 1'b0;
      v_q       <= '0;
      cfg_w_q   <= 4'd8;
      cfg_par_q <= PM_NONE;
      cfg_u2x_q <= 1'b0;
      dor_q     <= 1'b0;
    end else begin
      sync_q    <= {sync_q[0], rxd};
      baud_q    <= baud_d;
      state_q   <= state_d;
      samp_q    <= samp_d;
      bit_q     <= bit_d;
      shreg_q   <= shreg_d;
      par_q     <= par_d;
      v_q       <= v_d;
      cfg_w_q   <= cfg_w_d;
      cfg_par_q <= cfg_par_d;
      cfg_u2x_q <= cfg_u2x_d;
      dor_q     <= dor_d;
    end
  end

  usart_rx_fifo #(
    .WIDTH (FW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (cp2),
    .rst_i   (ireset),
    .flush_i (!rx_en),
    .push_i  (commit),
    .pop_i   (rx_pop),
    .wdata_i ({shreg_q, commit_fe, commit_pe}),
    .rdata_o (fifo_rdata),
    .empty_o (fifo_empty),
    .full_o  (fifo_full),
    .level_o (fifo_level)
  );

  assign rx_valid = !fifo_empty;
  assign rx_data  = fifo_rdata[FW-1:2];
  assign rx_fe    = fifo_rdata[1];
  assign rx_pe    = fifo_rdata[0];
  assign rx_dor   = dor_q;
  assign busy     = (state_q != ST_IDLE);

endmodule

// File: tb/tb_usart_rx_gen2.sv
// Self-checking bench for usart_rx_gen2: frame-level reference model with a
// per-cycle compare process, plus literal spot checks on key scenarios.
module tb_usart_rx_gen2;

  localparam int DW    = 9;
  localparam int DEPTH = 4;
  localparam int UW    = 12;
  localparam int LW    = $clog2(DEPTH+1);

  logic          cp2 = 1'b0;
  logic          ireset = 1'b1;
  logic          rx_en = 1'b0;
  logic          rxd = 1'b1;
  logic [UW-1:0] ubrr = 12'd259;
  logic          u2x = 1'b1;
  logic [2:0]    char_size = 3'd3;
  logic [1:0]    parity_mode = 2'b10;
  logic          rx_pop = 1'b0;
  logic          rx_valid;
  logic [DW-1:0] rx_data;
  logic          rx_fe;
  logic          rx_pe;
  logic          rx_dor;
  logic [LW-1:0] fifo_level;
  logic          busy;

  usart_rx_gen2 #(.DATA_W_MAX(DW), .FIFO_DEPTH(DEPTH), .UBRR_W(UW)) dut (
    .cp2         (cp2),
    .ireset      (ireset),
    .rx_en       (rx_en),
    .rxd         (rxd),
    .ubrr        (ubrr),
    .u2x         (u2x),
    .char_size   (char_size),
    .parity_mode (parity_mode),
    .rx_pop      (rx_pop),
    .rx_valid    (rx_valid),
    .rx_data     (rx_data),
    .rx_fe       (rx_fe),
    .rx_pe       (rx_pe),
    .rx_dor      (rx_dor),
    .fifo_level  (fifo_level),
    .busy        (busy)
  );

  // ---------------- clock / reset ----------------
  always #5 cp2 = ~cp2;

  int cyc = 0;
  always @(posedge cp2) cyc <= cyc + 1;

  initial begin
    #5_000_000;
    $display("FAIL watchdog timeout at cycle %0d", cyc);
    $fatal(1);
  end

  // ---------------- scoreboard / model ----------------
  logic [DW+1:0] exp_q[$];   // {data, fe, pe}
  logic          exp_dor = 1'b0;
  bit            check_en = 1'b0;
  int            checks = 0;
  int            errors = 0;
  int            frame_start = 0;
  int            rise_cyc = -1;
  logic [LW-1:0] prev_level = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got 0x%0h expected 0x%0h", name, cyc, act, exp);
    end
  endtask

  function automatic int width_of(input logic [2:0] cs);
    if (cs <= 3'd3) return int'(cs) + 5;
    if (cs == 3'd7) return 9;
    return 8;
  endfunction

  function automatic logic [DW+1:0] model_entry(input logic [8:0] data, input int w,
                                                input logic [1:0] pm, input logic par,
                                                input logic stop);
    logic [8:0] d;
    logic       x;
    logic       pe;
    d  = data & 9'((1 << w) - 1);
    x  = (^d) ^ par;
    pe = (pm == 2'b10) ? x : (pm == 2'b11) ? ~x : 1'b0;
    return {d, ~stop, pe};
  endfunction

  task automatic model_commit(input logic [DW+1:0] e);
    if (exp_q.size() < DEPTH) exp_q.push_back(e);
    else exp_dor = 1'b1;
  endtask

  task automatic model_pop();
    if (exp_q.size() != 0) begin
      void'(exp_q.pop_front());
      exp_dor = 1'b0;
    end
  endtask

  task automatic model_clear();
    exp_q.delete();
    exp_dor = 1'b0;
  endtask

  always @(negedge cp2) begin
    if (check_en) begin
      chk("valid", rx_valid, exp_q.size() != 0);
      chk("level", fifo_level, exp_q.size());
      chk("dor", rx_dor, exp_dor);
      chk("busy_idle", busy, 1'b0);
      if (exp_q.size() != 0) begin
        chk("head_data", rx_data, exp_q[0][DW+1:2]);
        chk("head_fe", rx_fe, exp_q[0][1]);
        chk("head_pe", rx_pe, exp_q[0][0]);
      end
    end
  end

  always @(negedge cp2) begin
    if (fifo_level > prev_level) rise_cyc = cyc;
    prev_level = fifo_level;
  end

  // ---------------- driver tasks ----------------
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge cp2);
      #1;
    end
  endtask

  task automatic pop1();
    rx_pop = 1'b1;
    tick(1);
    rx_pop = 1'b0;
    model_pop();
  endtask

  // nbits < 0 drives the whole frame plus one idle bit and updates the model.
  task automatic send_frame(input logic [8:0] data, input logic par, input logic stop,
                            input int nbits);
    int            w;
    int            bc;
    int            n;
    logic [1:0]    pm;
    logic          b[$];
    logic [DW+1:0] e;
    w  = width_of(char_size);
    pm = parity_mode;
    bc = (u2x ? 8 : 16) * (int'(ubrr) + 1);
    b.push_back(1'b0);
    for (int i = 0; i < w; i++) b.push_back(data[i]);
    if (pm[1]) b.push_back(par);
    b.push_back(stop);
    b.push_back(1'b1);
    e = model_entry(data, w, pm, par, stop);
    check_en    = 1'b0;
    frame_start = cyc;
    n = (nbits < 0) ? b.size() : nbits;
    for (int i = 0; i < n; i++) begin
      rxd = b[i];
      tick(bc);
    end
    if (nbits < 0) begin
      model_commit(e);
      check_en = 1'b1;
    end
  endtask

  // ---------------- directed sequence ----------------
  logic [8:0] dv[6];
  int         d_lat;
  int         fs0;

  initial begin
    dv = '{9'h011, 9'h022, 9'h033, 9'h0C4, 9'h055, 9'h0A6};

    // Reset values
    tick(3);
    chk("rst_valid", rx_valid, 1'b0);
    chk("rst_data", rx_data, 9'h000);
    chk("rst_fe", rx_fe, 1'b0);
    chk("rst_pe", rx_pe, 1'b0);
    chk("rst_dor", rx_dor, 1'b0);
    chk("rst_level", fifo_level, 0);
    chk("rst_busy", busy, 1'b0);
    ireset = 1'b0;
    rx_en  = 1'b1;
    check_en = 1'b1;
    tick(20);

    // 8E1, u2x, ubrr=259: good frame
    send_frame(9'h065, 1'b0, 1'b1, -1);
    chk("t1_data", rx_data, 9'h065);
    chk("t1_pe", rx_pe, 1'b0);
    chk("t1_fe", rx_fe, 1'b0);
    chk("t1_level", fifo_level, 1);

    ubrr = 12'd3;
    tick(300);
    send_frame(9'h067, 1'b1, 1'b1, -1);
    chk("t1b_level", fifo_level, 2);
    pop1();
    chk("t1b_data", rx_data, 9'h067);
    chk("t1b_pe", rx_pe, 1'b0);
    pop1();
    chk("t1b_empty", fifo_level, 0);

    // Parity error, then framing error on the next entry only
    send_frame(9'h065, 1'b1, 1'b1, -1);
    chk("t2_pe", rx_pe, 1'b1);
    send_frame(9'h03C, 1'b0, 1'b0, -1);
    chk("t2_fe_first", rx_fe, 1'b0);
    pop1();
    chk("t2_data", rx_data, 9'h03C);
    chk("t2_fe", rx_fe, 1'b1);
    chk("t2_pe_clear", rx_pe, 1'b0);
    pop1();

    // False start: low for 3 ticks
    check_en = 1'b0;
    rxd = 1'b0;
    tick(3 * 4);
    chk("fs_busy_seen", busy, 1'b1);
    rxd = 1'b1;
    tick(64);
    chk("fs_busy", busy, 1'b0);
    chk("fs_level", fifo_level, 0);
    check_en = 1'b1;

    // 9-bit, 16x, no parity; config disturbed mid-frame
    char_size = 3'd7; u2x = 1'b0; parity_mode = 2'b00;
    fork
      send_frame(9'h1A5, 1'b0, 1'b1, -1);
      begin
        tick(2 * 64);
        char_size = 3'd0; u2x = 1'b1; parity_mode = 2'b11;
      end
    join
    chk("t4_data", rx_data, 9'h1A5);
    chk("t4_pe", rx_pe, 1'b0);
    pop1();
    char_size = 3'd3; u2x = 1'b1; parity_mode = 2'b10;

    // FIFO fill, pop coinciding with commit, then overrun
    rx_en = 1'b0;
    tick(1);
    rx_en = 1'b1;
    model_clear();
    tick(8);
    rise_cyc = -1;
    send_frame(dv[0], ^dv[0][7:0], 1'b1, -1);
    fs0   = frame_start;
    d_lat = rise_cyc - fs0;
    chk("commit_latency_window", (d_lat >= 343 && d_lat <= 346), 1'b1);
    if (d_lat < 343 || d_lat > 346) d_lat = 344;
    for (int i = 1; i < 4; i++) send_frame(dv[i], ^dv[i][7:0], 1'b1, -1);
    chk("full_level", fifo_level, 4);
    fork
      send_frame(dv[4], ^dv[4][7:0], 1'b1, -1);
      begin
        tick(d_lat - 1);
        rx_pop = 1'b1;
        tick(1);
        rx_pop = 1'b0;
        model_pop();
      end
    join
    chk("popcommit_dor", rx_dor, 1'b0);
    chk("popcommit_level", fifo_level, 4);
    chk("popcommit_head", rx_data, 9'h022);
    send_frame(dv[5], ^dv[5][7:0], 1'b1, -1);
    chk("ovr_dor", rx_dor, 1'b1);
    chk("ovr_level", fifo_level, 4);
    chk("ovr_head", rx_data, 9'h022);
    pop1();
    chk("ovr_pop_dor", rx_dor, 1'b0);
    chk("ovr_pop_level", fifo_level, 3);
    pop1();

    // rx_en dropped mid-frame with two entries stored
    send_frame(9'h0F0, 1'b0, 1'b1, 4);
    chk("en_busy_mid", busy, 1'b1);
    chk("en_level_mid", fifo_level, 2);
    rx_en = 1'b0;
    tick(1);
    rx_en = 1'b1;
    rxd = 1'b1;
    model_clear();
    chk("en_busy", busy, 1'b0);
    chk("en_level", fifo_level, 0);
    chk("en_dor", rx_dor, 1'b0);
    chk("en_valid", rx_valid, 1'b0);
    check_en = 1'b1;
    tick(64);

    // Synchronous reset mid-frame
    send_frame(9'h05A, 1'b0, 1'b1, -1);
    send_frame(9'h081, 1'b0, 1'b1, 5);
    chk("rst2_busy_mid", busy, 1'b1);
    ireset = 1'b1;
    tick(1);
    ireset = 1'b0;
    rxd = 1'b1;
    model_clear();
    chk("rst2_valid", rx_valid, 1'b0);
    chk("rst2_data", rx_data, 9'h000);
    chk("rst2_fe", rx_fe, 1'b0);
    chk("rst2_pe", rx_pe, 1'b0);
    chk("rst2_dor", rx_dor, 1'b0);
    chk("rst2_level", fifo_level, 0);
    chk("rst2_busy", busy, 1'b0);
    check_en = 1'b1;
    tick(64);

    check_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
